// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mach_v_bp_pkg
// Brief    : Shared encodings and defaults for the fetch-stage branch predictor
// Revision : 1.0 - initial release
// ============================================================================
package mach_v_bp_pkg;

    // 2-bit saturating counter state
    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t SNT = 2'b00;  // strongly not taken
    localparam bp_ctr_t WNT = 2'b01;  // weakly not taken
    localparam bp_ctr_t WT  = 2'b10;  // weakly taken
    localparam bp_ctr_t ST  = 2'b11;  // strongly taken

    // Counter value after reset and after a fresh allocation
    localparam bp_ctr_t CTR_RESET = WNT;
    localparam bp_ctr_t CTR_ALLOC = WT;

    localparam int DEFAULT_ENTRIES = 64;

    // The upper bit of the counter is the taken/not-taken prediction
    function automatic logic ctr_predicts_taken(input bp_ctr_t ctr);
        return ctr[1];
    endfunction

endpackage : mach_v_bp_pkg
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Brief    : Fetch lookup, Execute resolution and statistics bundle of the
//            branch predictor
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;

    // Fetch-side lookup
    logic [31:0] PCF;
    logic        PrPCSrcF;
    logic [31:0] PrBTAF;

    // Execute-side resolution
    logic        ResolveE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] BTAE;
    logic        PrPCSrcE;
    logic [31:0] PrBTAE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;

    // Performance counters
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    // Pipeline side: drives PCs and resolution, consumes predictions
    modport master (
        output PCF, ResolveE, PCE, TakenE, BTAE, PrPCSrcE, PrBTAE,
        input  PrPCSrcF, PrBTAF, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );

    // Predictor side
    modport slave (
        input  PCF, ResolveE, PCE, TakenE, BTAE, PrPCSrcE, PrBTAE,
        output PrPCSrcF, PrBTAF, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );

endinterface : branch_predictor_if
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_counter2
// Brief    : Combinational next-state of a 2-bit saturating up/down counter
// Revision : 1.0 - initial release
// ============================================================================
module bp_sat_counter2
    import mach_v_bp_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    up,
    output bp_ctr_t ctr_next
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends
    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule : bp_sat_counter2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB with 2-bit counters; zero-latency fetch
//            lookup, Execute misprediction detection, training and
//            branch / misprediction statistics
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
    import mach_v_bp_pkg::*;
#(
    parameter int ENTRIES  = DEFAULT_ENTRIES,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic               CLK,
    input  logic               RESET,
    branch_predictor_if.slave  bp
);

    localparam int TAG_BITS = 30 - IDX_BITS;

    // BTB storage kept in flops so the whole table clears on reset
    logic                valid_tbl  [ENTRIES];
    logic [TAG_BITS-1:0] tag_tbl    [ENTRIES];
    logic [31:0]         target_tbl [ENTRIES];
    bp_ctr_t             ctr_tbl    [ENTRIES];

    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    // Lookup and update address split
    logic [IDX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic                lookup_hit;
    logic [IDX_BITS-1:0] update_idx;
    logic [TAG_BITS-1:0] update_tag;
    logic                update_hit;
    bp_ctr_t             update_ctr_next;
    logic                mispredict;

    // The two low PC bits never select an entry (instructions are word aligned)
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {bp.PCF[1:0], bp.PCE[1:0]};

    assign lookup_idx = bp.PCF[IDX_BITS+1:2];
    assign lookup_tag = bp.PCF[31:IDX_BITS+2];
    assign update_idx = bp.PCE[IDX_BITS+1:2];
    assign update_tag = bp.PCE[31:IDX_BITS+2];

    // Fetch lookup: reads the current table, no bypass of a same-cycle update
    always_comb begin
        lookup_hit  = valid_tbl[lookup_idx] && (tag_tbl[lookup_idx] == lookup_tag);
        bp.PrPCSrcF = 1'b0;
        bp.PrBTAF   = 32'd0;
        if (!RESET && lookup_hit) begin
            bp.PrPCSrcF = ctr_predicts_taken(ctr_tbl[lookup_idx]);
            bp.PrBTAF   = target_tbl[lookup_idx];
        end
    end

    // Execute resolution: wrong direction, or taken with a wrong target
    always_comb begin
        update_hit     = valid_tbl[update_idx] && (tag_tbl[update_idx] == update_tag);
        mispredict     = bp.ResolveE &&
                         ((bp.TakenE != bp.PrPCSrcE) ||
                          (bp.TakenE && (bp.PrBTAE != bp.BTAE)));
        bp.MispredictE = mispredict;
        bp.RedirectPCE = bp.TakenE ? bp.BTAE : 32'(bp.PCE + 32'd4);
    end

    // Counter next-state for the entry being trained
    bp_sat_counter2 u_update_ctr (
        .ctr      (ctr_tbl[update_idx]),
        .up       (bp.TakenE),
        .ctr_next (update_ctr_next)
    );

    // Table training: hits adjust counter (and target when taken),
    // taken misses allocate and evict whatever tag lived there
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_tbl[i]  <= 1'b0;
                tag_tbl[i]    <= '0;
                target_tbl[i] <= 32'd0;
                ctr_tbl[i]    <= CTR_RESET;
            end
        end else if (bp.ResolveE) begin
            if (update_hit) begin
                ctr_tbl[update_idx] <= update_ctr_next;
                if (bp.TakenE) begin
                    target_tbl[update_idx] <= bp.BTAE;
                end
            end else if (bp.TakenE) begin
                valid_tbl[update_idx]  <= 1'b1;
                tag_tbl[update_idx]    <= update_tag;
                target_tbl[update_idx] <= bp.BTAE;
                ctr_tbl[update_idx]    <= CTR_ALLOC;
            end
        end
    end

    // Performance counters, free-running modulo 2^32
    always_ff @(posedge CLK) begin
        if (RESET) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            if (bp.ResolveE) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

    assign bp.BranchCount     = branch_count;
    assign bp.MispredictCount = mispredict_count;

endmodule : branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor. It produces PrPCSrcF and PrBTAF, which the IF/ID register carries down the pipe.
- It is also the resolution end of the same path: it receives the predicted values back from Execute, detects mispredictions, supplies the redirect PC, and trains its tables.
- Structure: a direct-mapped BTB with one 2-bit saturating counter per entry, plus two performance counters.

Parameters:
- ENTRIES, 64, number of BTB entries; must be a power of two, 4..1024.
- IDX_BITS, 6, log2(ENTRIES); index = PC[IDX_BITS+1:2].
- TAG_BITS, 30-IDX_BITS (derived), tag = PC[31:IDX_BITS+2].

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- PCF  in  32  Fetch PC for lookup.
- PrPCSrcF  out  1  prediction: 1 = redirect fetch to PrBTAF.
- PrBTAF  out  32  predicted branch target.
- ResolveE  in  1  a conditional branch or JAL is resolved in Execute this cycle.
- PCE  in  32  PC of the resolving instruction.
- TakenE  in  1  actual outcome.
- BTAE  in  32  actual target.
- PrPCSrcE  in  1  prediction carried with the instruction.
- PrBTAE  in  32  predicted target carried with the instruction.
- MispredictE  out  1  Execute must flush Decode/Execute and redirect fetch.
- RedirectPCE  out  32  correct next PC.
- BranchCount  out  32  number of resolved branches.
- MispredictCount  out  32  number of mispredictions.

Behaviour:
- Reset, synchronous:
  - All valid bits are cleared, all counters set to 2'b01, targets and tags set to 0.
  - BranchCount and MispredictCount are set to 0.
  - While RESET is high, PrPCSrcF is 0 and PrBTAF is 0.
- Lookup is combinational on PCF, with zero latency:
  - hit = valid[idx] && tag[idx] == PCF tag.
  - PrPCSrcF = hit && ctr[idx][1].
  - PrBTAF = hit ? target[idx] : 0.
- Misprediction detection is combinational:
  - MispredictE = ResolveE && ((TakenE != PrPCSrcE) || (TakenE && PrBTAE != BTAE)).
  - RedirectPCE = TakenE ? BTAE : PCE+4, using 32-bit wrap-around arithmetic. Its value is don't-care when MispredictE is 0.
- Training happens on the rising edge when ResolveE is 1, using the index and tag of PCE:
  - Hit and TakenE=1: ctr increments, saturating at 11; target <= BTAE.
  - Hit and TakenE=0: ctr decrements, saturating at 00; target unchanged.
  - Miss and TakenE=1: allocate the entry (overwriting any other tag): valid=1, tag, target=BTAE, ctr=2'b10.
  - Miss and TakenE=0: no change.
- Performance counters, updated on the rising edge:
  - BranchCount increments when ResolveE is 1.
  - MispredictCount increments when MispredictE is 1.
  - Both wrap at 2^32.
- Simultaneous lookup and update of the same index in one cycle: the lookup returns the pre-update contents. There is no bypass.
- Stall and flush independence:
  - The predictor has no stall input, so lookup values simply follow PCF.
  - A flushed bubble must arrive with ResolveE=0 (IF/ID flush zeroes PrPCSrcD/PrBTAD), so no training and no counting occur.
- RESET asserted in the same cycle as ResolveE: reset wins, and no training or counting happens.
- Aliasing: different PCs sharing an index evict each other. Only allocation changes the tag; a hit update never does.

Decomposition:
- Shared package, mach_v_bp_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Reset counter value WNT; allocation counter value WT.
  - Default ENTRIES.
- One natural sub-module, bp_sat_counter2: a combinational 2-bit saturating up/down next-state function, reused per update.
- BTB arrays are registers inside branch_predictor so that they can be reset.

Test Plan:
1. Reset, then PCF=0x0000_0100 -> PrPCSrcF=0, PrBTAF=0; BranchCount=0, MispredictCount=0.
2. Resolve PCE=0x100, TakenE=1, BTAE=0x200, PrPCSrcE=0 -> MispredictE=1, RedirectPCE=0x200. Next cycle PCF=0x100 -> PrPCSrcF=1, PrBTAF=0x200; both counters=1.
3. Counter walk at PC 0x100 (entry at WT):
   - Resolve not-taken twice -> PrPCSrcF=0 after the second (WT->WNT->SNT).
   - Then taken twice -> PrPCSrcF=1 only after the second (SNT->WNT->WT).
   - Four consecutive taken -> saturates at ST; one not-taken keeps PrPCSrcF=1.
4. Target mismatch: the entry predicts 0x200, then resolve TakenE=1, BTAE=0x300, PrPCSrcE=1, PrBTAE=0x200 -> MispredictE=1, RedirectPCE=0x300; next lookup returns PrBTAF=0x300.
5. Not-taken mispredict: PCE=0x100, TakenE=0, PrPCSrcE=1 -> MispredictE=1, RedirectPCE=0x104. A not-taken miss at PCE=0x500 -> no allocation; lookup at 0x500 -> PrPCSrcF=0.
6. Aliasing and same-cycle behaviour:
   - ENTRIES=64: allocate 0x100, then taken at 0x200 (same index) -> lookup at 0x100 misses.
   - Same-cycle lookup/update of one index returns the old values.
   - RESET together with ResolveE -> no update, counters stay 0.
